call_panel: RTL and testbench
=============================

# call_panel

Landing and in-car call panel for the elevator controller, parameterised to `n` floors. It latches hall up/down button presses and car (cabin) button presses. Hall calls are driven as held request vectors into the elevator top level. Car calls are serialised one at a time onto its 5-bit `in_request` port. Every call is cleared when the elevator reports a dwell at the matching floor and direction, and the block drives the corresponding button lamps.

## Interface
- `n`, 20, number of floors (2..31); floors numbered 1..n, floor f maps to vector bit f-1
- `clk` input 1: single system clock, rising edge
- `reset` input 1: asynchronous, active-low; low clears all state
- `hall_up_btn` input n: hall up buttons, level, synchronous to `clk`; bit n-1 (top floor) ignored
- `hall_down_btn` input n: hall down buttons, level, synchronous; bit 0 (floor 1) ignored
- `car_btn` input n: cabin floor buttons, level, synchronous
- `Floor` input 5: current car floor from elevator, 1..n
- `up` input 1: elevator moving up
- `down` input 1: elevator moving down
- `waitn` input 1: 1 = car stopped at `Floor` with doors dwelling (service event)
- `up_request` output n: latched hall up calls, held until serviced
- `down_request` output n: latched hall down calls, held until serviced
- `in_request` output 5: serialised car call; f for one cycle per new call, 0 = none
- `car_lamp` output n: pending car calls (lamp drive)
- `up_lamp` output n: equals `up_request`
- `down_lamp` output n: equals `down_request`

## Operation
- Button edge detect: registered copies of all three button vectors. Press = `btn & ~btn_q`. Holding a button produces one press only.
- Direction tracker `last_dir` ∈ {IDLE, UP, DOWN}:
  - `up`=1 → UP; `down`=1 → DOWN; both 1 → unchanged.
  - Holds when both are 0, so direction is remembered through the dwell.
- Service at dwell (`waitn`=1, f=`Floor`, 1≤f≤n; out-of-range `Floor` clears nothing):
  - car call f cleared.
  - UP: up call f cleared; at the top floor, down call f also cleared.
  - DOWN: down call f cleared; at floor 1, up call f also cleared.
  - IDLE: both hall calls at f cleared.
- Hall latch: a press sets the bit. A press on a bit that is being cleared in the same cycle is dropped, because the car is already serving it. Ignored bits (top up, bottom down) never set.
- Car pending `car_pend`: set on press, cleared on service. Same same-cycle rule: service wins.
- Car serialiser: `car_sent` marks pending calls already presented.
  - Each cycle, if `car_pend & ~car_sent` is nonzero, select by round-robin from pointer `ptr`: lowest index ≥ `ptr`, else wrap to lowest overall.
  - Drive `in_request` = index+1 registered, set that `car_sent` bit, `ptr` = index+1 mod n.
  - Otherwise `in_request` = 0.
  - A `car_sent` bit clears together with its `car_pend` bit.
  - Re-pressing a pending car button neither re-sends nor changes state.
- Pressing a car button for the floor currently being dwelt at is dropped, as for hall calls.

## Timing
- All state is reset-asynchronous. After `reset` low, all outputs are 0, `last_dir`=IDLE, `ptr`=0, and all `*_q`, `car_pend` and `car_sent` are 0.
- Hall call latency: button rises before edge k → `up_request`/`down_request` bit high after edge k.
- Car call: button rises before edge k → `car_lamp` high after k, `in_request`=f after k+1, `in_request` back to 0 (or the next call) after k+2.
- Throughput: at most one car call presented per cycle. m simultaneous presses are presented on m consecutive cycles in round-robin order.
- Service clear: `waitn`=1 sampled at edge k → bits low after edge k. Clearing persists every cycle while `waitn`=1.
- `reset` asserted mid-operation: outputs go to 0 immediately, without waiting for a clock edge. After release, buttons still held high do not register a press until released and pressed again, because `btn_q` resets to 0 but the first sampled edge is filtered. This holds since `btn_q` is loaded, not set, on the first post-reset edge: filtering is done by a one-cycle `arm` flag set on the first clock after reset.

## Test plan
- Reset: drive `reset`=0 with all buttons pressed → every output 0. Release `reset` while holding buttons → no request bits set.
- Hall latch/clear: press `hall_up_btn[4]` (floor 5), `last_dir`=UP → `up_request`=0x10 after 1 edge. Then `Floor`=5, `waitn`=1 → `up_request`=0 next edge. `down_request[4]` set earlier stays 1.
- Car serialisation: press `car_btn` bits 2, 7, 12 in one cycle with `ptr`=5 → `in_request` sequence 8, 13, 3, then 0. `car_lamp`=0x1084 until each floor is serviced.
- Boundary floors: press `hall_up_btn[n-1]` and `hall_down_btn[0]` → no bits set. Dwell at floor n with `last_dir`=UP and `down_request[n-1]`=1 → down call cleared.
- Simultaneous press/clear: `waitn`=1, `Floor`=3, `last_dir`=IDLE, press `hall_down_btn[2]` and `car_btn[2]` in the same cycle → neither latched and `in_request` stays 0.
- Mid-operation reset: three car calls pending, one already sent. Assert `reset` between edges → `in_request`, `car_lamp` and hall vectors go to 0 immediately, and no further `in_request` values appear after release.

Source files
------------

// File: rtl/call_panel_if.sv
// Elevator call panel bus: buttons and dwell status from the car,
// latched calls, serialised car call and lamp drives back out.
interface call_panel_if #(
  parameter int N = 20
);
  logic [N-1:0] hall_up_btn;
  logic [N-1:0] hall_down_btn;
  logic [N-1:0] car_btn;
  logic [4:0]   Floor;
  logic         up;
  logic         down;
  logic         waitn;
  logic [N-1:0] up_request;
  logic [N-1:0] down_request;
  logic [4:0]   in_request;
  logic [N-1:0] car_lamp;
  logic [N-1:0] up_lamp;
  logic [N-1:0] down_lamp;

  modport master (
    output hall_up_btn,
    output hall_down_btn,
    output car_btn,
    output Floor,
    output up,
    output down,
    output waitn,
    input  up_request,
    input  down_request,
    input  in_request,
    input  car_lamp,
    input  up_lamp,
    input  down_lamp
  );

  modport slave (
    input  hall_up_btn,
    input  hall_down_btn,
    input  car_btn,
    input  Floor,
    input  up,
    input  down,
    input  waitn,
    output up_request,
    output down_request,
    output in_request,
    output car_lamp,
    output up_lamp,
    output down_lamp
  );
endinterface

// File: rtl/call_panel.sv
// Call panel: latches hall and car calls, clears them on dwell,
// and presents car calls one per cycle in round-robin order.
module call_panel #(
  parameter int n = 20
) (
  input  logic  clk,
  input  logic  reset,
  call_panel_if.slave bus
);

  localparam logic [4:0]   NF    = 5'(n);
  localparam logic [n-1:0] ONE   = {{(n-1){1'b0}}, 1'b1};
  localparam logic [n-1:0] UP_OK = {1'b0, {(n-1){1'b1}}};
  localparam logic [n-1:0] DN_OK = {{(n-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } dir_e;

  dir_e dir_q, dir_d;
  logic dir_up, dir_dn;

  logic         arm_q;
  logic [n-1:0] hu_q, hd_q, cb_q;
  logic [n-1:0] hu_p, hd_p, cb_p;
  logic [n-1:0] up_q, up_d;
  logic [n-1:0] dn_q, dn_d;
  logic [n-1:0] pend_q, pend_d;
  logic [n-1:0] sent_q, sent_d;
  logic [4:0]   ptr_q, ptr_d;
  logic [4:0]   inr_q, inr_d;

  logic         svc, at_top, at_bot;
  logic [n-1:0] hit, up_clr, dn_clr;
  logic [n-1:0] cand, sel;
  logic         hit_hi, hit_lo;
  logic [4:0]   idx_hi, idx_lo, sel_idx;

  // Direction tracker
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dir_q <= IDLE;
    else        dir_q <= dir_d;
  end

  always_comb begin
    dir_d = dir_q;
    unique case (1'b1)
      (bus.up & ~bus.down): dir_d = UP;
      (bus.down & ~bus.up): dir_d = DN;
      default:              dir_d = dir_q;
    endcase
  end

  always_comb begin
    dir_up = (dir_q == UP);
    dir_dn = (dir_q == DN);
  end

  // First post-reset edge only loads the button copies
  assign hu_p = arm_q ? (bus.hall_up_btn & ~hu_q) : '0;
  assign hd_p = arm_q ? (bus.hall_down_btn & ~hd_q) : '0;
  assign cb_p = arm_q ? (bus.car_btn & ~cb_q) : '0;

  assign svc = bus.waitn && (bus.Floor != 5'd0) && (bus.Floor <= NF);
  assign hit = svc ? (ONE << (bus.Floor - 5'd1)) : '0;
  assign at_top = (bus.Floor == NF);
  assign at_bot = (bus.Floor == 5'd1);

  always_comb begin
    up_clr = '0;
    dn_clr = '0;
    unique case (1'b1)
      dir_up: begin
        up_clr = hit;
        dn_clr = at_top ? hit : '0;
      end
      dir_dn: begin
        dn_clr = hit;
        up_clr = at_bot ? hit : '0;
      end
      default: begin
        up_clr = hit;
        dn_clr = hit;
      end
    endcase
  end

  assign up_d   = (up_q | (hu_p & UP_OK)) & ~up_clr;
  assign dn_d   = (dn_q | (hd_p & DN_OK)) & ~dn_clr;
  assign pend_d = (pend_q | cb_p) & ~hit;

  // Round-robin pick: lowest at/above ptr, else lowest overall
  assign cand = pend_q & ~sent_q;

  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (cand[i]) begin
        hit_lo = 1'b1;
        idx_lo = 5'(i);
        if (5'(i) >= ptr_q) begin
          hit_hi = 1'b1;
          idx_hi = 5'(i);
        end
      end
    end
  end

  always_comb begin
    sel_idx = hit_hi ? idx_hi : idx_lo;
    sel     = '0;
    inr_d   = '0;
    ptr_d   = ptr_q;
    if (hit_lo) begin
      sel   = ONE << sel_idx;
      inr_d = sel_idx + 5'd1;
      ptr_d = (sel_idx == NF - 5'd1) ? 5'd0 : sel_idx + 5'd1;
    end
  end

  assign sent_d = (sent_q | sel) & ~hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arm_q  <= 1'b0;
      hu_q   <= '0;
      hd_q   <= '0;
      cb_q   <= '0;
      up_q   <= '0;
      dn_q   <= '0;
      pend_q <= '0;
      sent_q <= '0;
      ptr_q  <= '0;
      inr_q  <= '0;
    end else begin
      arm_q  <= 1'b1;
      hu_q   <= bus.hall_up_btn;
      hd_q   <= bus.hall_down_btn;
      cb_q   <= bus.car_btn;
      up_q   <= up_d;
      dn_q   <= dn_d;
      pend_q <= pend_d;
      sent_q <= sent_d;
      ptr_q  <= ptr_d;
      inr_q  <= inr_d;
    end
  end

  assign bus.up_request   = up_q;
  assign bus.down_request = dn_q;
  assign bus.up_lamp      = up_q;
  assign bus.down_lamp    = dn_q;
  assign bus.car_lamp     = pend_q;
  assign bus.in_request   = inr_q;

endmodule

// File: tb/tb_call_panel.sv
// Bench for call_panel: hall-call vector table plus car-call
// sequences, with serialised car calls checked from a queue.
module tb_call_panel;

  localparam int N = 20;

  logic clk = 1'b0;
  logic reset;

  call_panel_if #(.N(N)) bus ();

  call_panel #(.n(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] hu;
    logic [N-1:0] hd;
    logic [4:0]   fl;
    logic         u;
    logic         d;
    logic         w;
    logic [N-1:0] eu;
    logic [N-1:0] ed;
  } vec_t;

  vec_t tv[$];
  logic [4:0] sb[$];
  logic [4:0] sb_e;
  int checks = 0;
  int fails  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(
    input logic [N-1:0] hu, input logic [N-1:0] hd,
    input logic [N-1:0] cb, input logic [4:0] fl,
    input logic u, input logic d, input logic w);
    bus.hall_up_btn   = hu;
    bus.hall_down_btn = hd;
    bus.car_btn       = cb;
    bus.Floor         = fl;
    bus.up            = u;
    bus.down          = d;
    bus.waitn         = w;
  endtask

  task automatic add(
    input logic [N-1:0] hu, input logic [N-1:0] hd,
    input logic [4:0] fl, input logic u, input logic d,
    input logic w, input logic [N-1:0] eu,
    input logic [N-1:0] ed);
    vec_t v;
    v.hu = hu; v.hd = hd; v.fl = fl;
    v.u = u; v.d = d; v.w = w;
    v.eu = eu; v.ed = ed;
    tv.push_back(v);
  endtask

  task automatic chk_all0(string nm);
    chk({nm, "_up"}, 32'(bus.up_request), 0);
    chk({nm, "_dn"}, 32'(bus.down_request), 0);
    chk({nm, "_lamp"}, 32'(bus.car_lamp), 0);
    chk({nm, "_in"}, 32'(bus.in_request), 0);
  endtask

  // Every nonzero in_request must match the next queued call
  always @(posedge clk) begin
    #1;
    if (bus.in_request !== 5'd0) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got %0d expected none",
                 bus.in_request);
      end else begin
        sb_e = sb.pop_front();
        if (bus.in_request !== sb_e) begin
          fails++;
          $display("FAIL sb_order: got %0d expected %0d",
                   bus.in_request, sb_e);
        end
      end
    end
  end

  initial begin
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add('h10, 'h10, 0, 0, 0, 0, 'h10, 'h10);
    add('h10, 'h10, 5, 0, 0, 1, 0, 'h10);
    add(0, 0, 0, 0, 0, 0, 0, 'h10);
    add('h80000, 'h1, 0, 0, 0, 0, 0, 'h10);
    add(0, 'h80000, 0, 0, 0, 0, 0, 'h80010);
    add(0, 0, 20, 0, 0, 1, 0, 'h10);
    add('h1, 0, 0, 0, 1, 0, 'h1, 'h10);
    add(0, 0, 1, 0, 0, 1, 0, 'h10);
    add('h4, 0, 0, 0, 0, 0, 'h4, 'h10);
    add(0, 0, 0, 0, 0, 1, 'h4, 'h10);
    add(0, 0, 21, 0, 0, 1, 'h4, 'h10);
    add(0, 0, 3, 0, 0, 1, 'h4, 'h10);
    add(0, 0, 5, 0, 0, 1, 'h4, 0);
    add(0, 0, 0, 1, 0, 0, 'h4, 0);
    add(0, 0, 3, 0, 0, 1, 0, 0);
    add(0, 'h4, 0, 1, 1, 0, 0, 'h4);
    add(0, 0, 3, 0, 0, 1, 0, 'h4);
    add(0, 0, 0, 0, 1, 0, 0, 'h4);
    add(0, 0, 3, 0, 0, 1, 0, 0);

    // Reset with every button held
    reset = 1'b0;
    drv('1, '1, '1, 0, 0, 0, 0);
    tick();
    tick();
    chk_all0("rst");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all0($sformatf("rst_hold%0d", i));
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Hall calls, direction, boundary floors
    foreach (tv[i]) begin
      drv(tv[i].hu, tv[i].hd, 0, tv[i].fl,
          tv[i].u, tv[i].d, tv[i].w);
      tick();
      chk($sformatf("row%0d_up", i),
          32'(bus.up_request), 32'(tv[i].eu));
      chk($sformatf("row%0d_dn", i),
          32'(bus.down_request), 32'(tv[i].ed));
      chk($sformatf("row%0d_ulamp", i),
          32'(bus.up_lamp), 32'(tv[i].eu));
      chk($sformatf("row%0d_dlamp", i),
          32'(bus.down_lamp), 32'(tv[i].ed));
      chk($sformatf("row%0d_clamp", i),
          32'(bus.car_lamp), 0);
    end

    // Single car call, then serialisation from ptr=5
    sb.push_back(5'd5);
    drv(0, 0, 'h10, 0, 0, 0, 0);
    tick();
    chk("car1_lamp", 32'(bus.car_lamp), 'h10);
    chk("car1_in0", 32'(bus.in_request), 0);
    tick();
    chk("car1_in", 32'(bus.in_request), 5);
    tick();
    chk("car1_hold", 32'(bus.in_request), 0);
    drv(0, 0, 0, 5, 0, 0, 1);
    tick();
    chk("car1_svc", 32'(bus.car_lamp), 0);

    sb.push_back(5'd8);
    sb.push_back(5'd13);
    sb.push_back(5'd3);
    drv(0, 0, 'h1084, 0, 0, 0, 0);
    tick();
    chk("rr_lamp", 32'(bus.car_lamp), 'h1084);
    chk("rr_in0", 32'(bus.in_request), 0);
    tick();
    chk("rr_a", 32'(bus.in_request), 8);
    tick();
    chk("rr_b", 32'(bus.in_request), 13);
    tick();
    chk("rr_c", 32'(bus.in_request), 3);
    drv(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rr_end", 32'(bus.in_request), 0);
    drv(0, 0, 'h80, 0, 0, 0, 0);
    tick();
    chk("repress_in", 32'(bus.in_request), 0);
    chk("repress_lamp", 32'(bus.car_lamp), 'h1084);
    tick();
    chk("repress_in2", 32'(bus.in_request), 0);
    drv(0, 0, 0, 3, 0, 0, 1);
    tick();
    chk("svc3", 32'(bus.car_lamp), 'h1080);
    drv(0, 0, 0, 8, 0, 0, 1);
    tick();
    chk("svc8", 32'(bus.car_lamp), 'h1000);
    drv(0, 0, 0, 13, 0, 0, 1);
    tick();
    chk("svc13", 32'(bus.car_lamp), 0);
    drv(0, 0, 0, 0, 0, 0, 0);

    // Back to IDLE: press and clear in the same cycle
    reset = 1'b0;
    #2;
    chk_all0("rst2");
    tick();
    reset = 1'b1;
    tick();
    drv('h4, 'h4, 'h4, 3, 0, 0, 1);
    tick();
    chk("same_up", 32'(bus.up_request), 0);
    chk("same_dn", 32'(bus.down_request), 0);
    chk("same_lamp", 32'(bus.car_lamp), 0);
    drv(0, 0, 0, 3, 0, 0, 1);
    tick();
    chk("same_in", 32'(bus.in_request), 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    tick();
    drv('h4, 'h4, 0, 0, 0, 0, 0);
    tick();
    chk("idle_up_set", 32'(bus.up_request), 'h4);
    chk("idle_dn_set", 32'(bus.down_request), 'h4);
    drv(0, 0, 0, 3, 0, 0, 1);
    tick();
    chk("idle_up_clr", 32'(bus.up_request), 0);
    chk("idle_dn_clr", 32'(bus.down_request), 0);

    // Reset with car calls pending and one already sent
    sb.push_back(5'd1);
    drv('h2, 0, 'h7, 0, 0, 0, 0);
    tick();
    chk("mid_lamp", 32'(bus.car_lamp), 'h7);
    chk("mid_up", 32'(bus.up_request), 'h2);
    tick();
    chk("mid_in", 32'(bus.in_request), 1);
    #3;
    reset = 1'b0;
    #1;
    chk_all0("mid_rst");
    tick();
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("post_in%0d", i), 32'(bus.in_request), 0);
    end
    chk("post_lamp", 32'(bus.car_lamp), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
